// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU codes,
// condition/command constants, mux selects and the ALU-function decoder.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_EOR = 4'b0100;
   localparam logic [3:0] ALU_MOV = 4'b0101;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       wr_ok;
   } alu_dec_t;

   // CMP and unknown commands never write the register file
   function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
      alu_dec_t d;
      d.ctrl  = ALU_ADD;
      d.wr_ok = 1'b1;
      case (cmd)
         CMD_ADD: d.ctrl = ALU_ADD;
         CMD_SUB: d.ctrl = ALU_SUB;
         CMD_AND: d.ctrl = ALU_AND;
         CMD_ORR: d.ctrl = ALU_ORR;
         CMD_EOR: d.ctrl = ALU_EOR;
         CMD_MOV: d.ctrl = ALU_MOV;
         CMD_CMP: begin d.ctrl = ALU_SUB; d.wr_ok = 1'b0; end
         default: begin d.ctrl = ALU_ADD; d.wr_ok = 1'b0; end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_condition_check.sv
// NZCV flags register plus combinational condition evaluation against the
// stored flags; reset clears the flags and wins over a pending load.
module condition_check
   import control_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       flags_we_i,
   output logic       cond_ex_o
);

   logic [3:0] flags_q, flags_d;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      flags_d = flags_q;
      if (flags_we_i) flags_d = alu_flags_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) flags_q <= 4'b0000;
      else         flags_q <= flags_d;
   end

   // 1111 and the overflow/unsigned-compare codes are not supported: never execute
   always_comb begin
      case (cond_i)
         COND_EQ: cond_ex_o = z;
         COND_NE: cond_ex_o = ~z;
         COND_CS: cond_ex_o = c;
         COND_CC: cond_ex_o = ~c;
         COND_MI: cond_ex_o = n;
         COND_PL: cond_ex_o = ~n;
         COND_GE: cond_ex_o = (n == v);
         COND_LT: cond_ex_o = (n != v);
         COND_GT: cond_ex_o = ~z & (n == v);
         COND_LE: cond_ex_o = z | (n != v);
         COND_AL: cond_ex_o = 1'b1;
         default: cond_ex_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the shared multicycle datapath, with instruction, ALU and
// condition decode; reset forces all strobes low and the decode to FETCH.
module multicycle_control_unit
   import control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] instruction,
   input  logic [3:0]  alu_flags,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [1:0]  reg_src,
   output logic [3:0]  alu_control
);

   logic [3:0] cond, cmd, rd;
   logic [1:0] op;
   logic [5:0] funct;
   logic       unused_rn;
   alu_dec_t   dec;
   logic       is_cmp, cond_ex, flags_we;
   state_t     state_q, state_d, st;

   assign cond      = instruction[19:16];
   assign op        = instruction[15:14];
   assign funct     = instruction[13:8];
   assign unused_rn = ^instruction[7:4];
   assign rd        = instruction[3:0];
   assign cmd       = funct[4:1];
   assign dec       = alu_decode(cmd);
   assign is_cmp    = (cmd == CMD_CMP);

   assign flags_we = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) &&
                     (funct[0] || is_cmp) && cond_ex;

   condition_check u_cond (
      .clk_i       (clk),
      .reset_i     (reset),
      .cond_i      (cond),
      .alu_flags_i (alu_flags),
      .flags_we_i  (flags_we),
      .cond_ex_o   (cond_ex)
   );

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign imm_src = (op == 2'b11) ? 2'b00 : op;
   assign reg_src = {op == 2'b01, op == 2'b10};

   // Under reset the outputs decode as FETCH, so an aborted instruction cannot strobe
   assign st = reset ? S_FETCH : state_q;

   always_comb begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_RD2;
      alu_control = ALU_ADD;
      case (st)
         S_FETCH: begin
            ir_write = 1'b1; alu_src_a = 1'b1; alu_src_b = SRCB_FOUR;
            result_src = RES_ALU; pc_write = 1'b1;
         end
         S_DECODE: begin
            alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU;
         end
         S_MEMADR:   alu_src_b = SRCB_IMM;
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = RES_DATA; reg_write = cond_ex;
         end
         S_MEMWRITE: begin
            adr_src = 1'b1; mem_write = cond_ex;
         end
         S_EXECUTER: alu_control = dec.ctrl;
         S_EXECUTEI: begin
            alu_src_b = SRCB_IMM; alu_control = dec.ctrl;
         end
         S_ALUWB: begin
            reg_write = cond_ex & dec.wr_ok;
            pc_write  = cond_ex & (rd == 4'd15);
         end
         S_BRANCH: begin
            alu_src_b = SRCB_IMM; result_src = RES_ALU; pc_write = cond_ex;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle controller: per-cycle state/strobe checks per instruction class.
module tb_multicycle_control_unit;
   import control_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] instruction;
   logic [3:0]  alu_flags;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
   logic [3:0]  alu_control;

   int tests = 0;
   int fails = 0;

   multicycle_control_unit dut (
      .clk(clk), .reset(reset), .instruction(instruction), .alu_flags(alu_flags),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; instruction = 20'hE3A01; alu_flags = 4'b0000;
      repeat (2) begin @(posedge clk); #2; end
      tests++; if (dut.state_q !== S_FETCH) begin fails++; $display("FAIL reset_state got %0d want %0d", dut.state_q, S_FETCH); end
      tests++; if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin fails++; $display("FAIL reset_strobes got %b want 0000", {pc_write, ir_write, reg_write, mem_write}); end
      tests++; if (dut.u_cond.flags_q !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", dut.u_cond.flags_q); end
      tests++; if ({alu_src_a, alu_src_b, result_src} !== 5'b11010) begin fails++; $display("FAIL reset_fetch_decode got %b want 11010", {alu_src_a, alu_src_b, result_src}); end
      reset = 1'b0; #1;
      tests++; if ({ir_write, pc_write} !== 2'b11) begin fails++; $display("FAIL release_fetch got %b want 11", {ir_write, pc_write}); end
   endtask

   task automatic test_mov_imm();
      state_t exp[4];
      exp = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
      instruction = 20'hE3A01;
      for (int i = 0; i < 4; i++) begin
         tests++; if (dut.state_q !== exp[i]) begin fails++; $display("FAIL mov_state[%0d] got %0d want %0d", i, dut.state_q, exp[i]); end
         tests++; if (reg_write !== (i == 3)) begin fails++; $display("FAIL mov_reg_write[%0d] got %b want %b", i, reg_write, i == 3); end
         if (i == 2) begin
            tests++; if ({alu_control, alu_src_b} !== {ALU_MOV, SRCB_IMM}) begin fails++; $display("FAIL mov_alu got %b want %b", {alu_control, alu_src_b}, {ALU_MOV, SRCB_IMM}); end
         end
         @(posedge clk); #2;
      end
      tests++; if (dut.state_q !== S_FETCH) begin fails++; $display("FAIL mov_return got %0d want %0d", dut.state_q, S_FETCH); end
   endtask

   task automatic test_ldr_str();
      state_t exp[5];
      exp = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      instruction = 20'hE5921;
      for (int i = 0; i < 5; i++) begin
         tests++; if (dut.state_q !== exp[i]) begin fails++; $display("FAIL ldr_state[%0d] got %0d want %0d", i, dut.state_q, exp[i]); end
         tests++; if ({reg_write, mem_write} !== {i == 4, 1'b0}) begin fails++; $display("FAIL ldr_strobes[%0d] got %b want %b", i, {reg_write, mem_write}, {i == 4, 1'b0}); end
         if (i == 3) begin tests++; if (adr_src !== 1'b1) begin fails++; $display("FAIL ldr_adr_src got %b want 1", adr_src); end end
         if (i == 4) begin tests++; if (result_src !== RES_DATA) begin fails++; $display("FAIL ldr_result_src got %b want 01", result_src); end end
         if (i == 1) begin tests++; if ({imm_src, reg_src} !== 4'b0110) begin fails++; $display("FAIL ldr_imm_reg_src got %b want 0110", {imm_src, reg_src}); end end
         @(posedge clk); #2;
      end
      instruction = 20'hE5821;
      exp = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH};
      for (int i = 0; i < 5; i++) begin
         tests++; if (dut.state_q !== exp[i]) begin fails++; $display("FAIL str_state[%0d] got %0d want %0d", i, dut.state_q, exp[i]); end
         tests++; if ({mem_write, reg_write} !== {i == 3, 1'b0}) begin fails++; $display("FAIL str_strobes[%0d] got %b want %b", i, {mem_write, reg_write}, {i == 3, 1'b0}); end
         if (i < 4) begin @(posedge clk); #2; end
      end
   endtask

   task automatic test_cmp_branch();
      instruction = 20'hE1510; alu_flags = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         if (i >= 2) begin tests++; if (reg_write !== 1'b0) begin fails++; $display("FAIL cmp_reg_write[%0d] got %b want 0", i, reg_write); end end
         @(posedge clk); #2;
      end
      alu_flags = 4'b0000;
      tests++; if (dut.u_cond.flags_q !== 4'b0100) begin fails++; $display("FAIL cmp_flags got %b want 0100", dut.u_cond.flags_q); end
      instruction = 20'h0A000;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin tests++; if ({imm_src, reg_src} !== 4'b1001) begin fails++; $display("FAIL beq_imm_reg_src got %b want 1001", {imm_src, reg_src}); end end
         if (i == 2) begin
            tests++; if (dut.state_q !== S_BRANCH) begin fails++; $display("FAIL beq_state got %0d want %0d", dut.state_q, S_BRANCH); end
            tests++; if (pc_write !== 1'b1) begin fails++; $display("FAIL beq_pc_write got %b want 1", pc_write); end
         end
         @(posedge clk); #2;
      end
      instruction = 20'h1A000;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin tests++; if (pc_write !== 1'b0) begin fails++; $display("FAIL bne_pc_write got %b want 0", pc_write); end end
         @(posedge clk); #2;
      end
      tests++; if (dut.state_q !== S_FETCH) begin fails++; $display("FAIL bne_return got %0d want %0d", dut.state_q, S_FETCH); end
   endtask

   task automatic test_cond_fail();
      state_t exp[5];
      exp = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH};
      instruction = 20'hE1510; alu_flags = 4'b0000;
      repeat (4) begin @(posedge clk); #2; end
      instruction = 20'h00911; alu_flags = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tests++; if (dut.state_q !== exp[i]) begin fails++; $display("FAIL adds_fail_state[%0d] got %0d want %0d", i, dut.state_q, exp[i]); end
         tests++; if ({reg_write, pc_write} !== {1'b0, i == 0 || i == 4}) begin fails++; $display("FAIL adds_fail_strobes[%0d] got %b want %b", i, {reg_write, pc_write}, {1'b0, i == 0 || i == 4}); end
         if (i < 4) begin @(posedge clk); #2; end
      end
      alu_flags = 4'b0000;
      tests++; if (dut.u_cond.flags_q !== 4'b0000) begin fails++; $display("FAIL adds_fail_flags got %b want 0000", dut.u_cond.flags_q); end
   endtask

   task automatic test_cond_codes();
      logic [3:0] tf[8];
      logic [3:0] tc[8];
      logic       te[8];
      tf = '{4'b1000, 4'b1000, 4'b1001, 4'b0100, 4'b0010, 4'b0000, 4'b1111, 4'b1111};
      tc = '{4'b1011, 4'b1010, 4'b1100, 4'b1101, 4'b0010, 4'b1110, 4'b1111, 4'b0110};
      te = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
      for (int k = 0; k < 8; k++) begin
         instruction = 20'hE1510; alu_flags = tf[k];
         repeat (4) begin @(posedge clk); #2; end
         alu_flags = 4'b0000;
         instruction = {tc[k], 16'hA000};
         repeat (2) begin @(posedge clk); #2; end
         tests++; if (pc_write !== te[k]) begin fails++; $display("FAIL cond_%b_flags_%b pc_write got %b want %b", tc[k], tf[k], pc_write, te[k]); end
         @(posedge clk); #2;
      end
   endtask

   task automatic test_rd15_undef();
      instruction = 20'hE3A0F;
      repeat (3) begin @(posedge clk); #2; end
      tests++; if ({pc_write, reg_write} !== 2'b11) begin fails++; $display("FAIL rd15_aluwb got %b want 11", {pc_write, reg_write}); end
      @(posedge clk); #2;
      instruction = 20'hEC000;
      @(posedge clk); #2;
      tests++; if (dut.state_q !== S_DECODE) begin fails++; $display("FAIL undef_decode got %0d want %0d", dut.state_q, S_DECODE); end
      tests++; if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin fails++; $display("FAIL undef_strobes got %b want 0000", {pc_write, ir_write, reg_write, mem_write}); end
      tests++; if (imm_src !== 2'b00) begin fails++; $display("FAIL undef_imm_src got %b want 00", imm_src); end
      @(posedge clk); #2;
      tests++; if (dut.state_q !== S_FETCH) begin fails++; $display("FAIL undef_return got %0d want %0d", dut.state_q, S_FETCH); end
   endtask

   task automatic test_reset_mid();
      instruction = 20'hE1510; alu_flags = 4'b0100;
      repeat (4) begin @(posedge clk); #2; end
      alu_flags = 4'b0000;
      instruction = 20'hE5921;
      repeat (3) begin @(posedge clk); #2; end
      tests++; if (dut.state_q !== S_MEMREAD) begin fails++; $display("FAIL mid_pre_state got %0d want %0d", dut.state_q, S_MEMREAD); end
      reset = 1'b1; #1;
      tests++; if ({pc_write, ir_write, reg_write, mem_write, adr_src} !== 5'b00000) begin fails++; $display("FAIL mid_reset_outputs got %b want 00000", {pc_write, ir_write, reg_write, mem_write, adr_src}); end
      @(posedge clk); #2;
      tests++; if (dut.state_q !== S_FETCH) begin fails++; $display("FAIL mid_reset_state got %0d want %0d", dut.state_q, S_FETCH); end
      tests++; if (dut.u_cond.flags_q !== 4'b0000) begin fails++; $display("FAIL mid_reset_flags got %b want 0000", dut.u_cond.flags_q); end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_ldr_str();
      test_cmp_branch();
      test_cond_fail();
      test_cond_codes();
      test_rd15_undef();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
